fir_stream_host: RTL and testbench
==================================

Name: fir_stream_host

Overview:
- Host-side end of the FIR block's serial valid/ready link.
- Serializes parallel sample words onto the serial input that feeds the deserializer, and reassembles the filtered serial output stream back into parallel words.
- Used for bench stimulus and on-chip loopback around the serial FIR pipeline.
- TX and RX paths are independent and run concurrently.

Parameters:
- DATA_WIDTH, 24, bits per word on both the TX and RX paths; must be 2 or more.
- COUNT_WIDTH, 16, width of the word counters; only used when FIR_HOST_WORD_COUNT_EN is defined.

Ports:
- i_clk  in  1  single clock for the block.
- i_rst  in  1  asynchronous reset, active-high.
- i_en  in  1  global enable. When low, all state is frozen and all handshake outputs are forced to 0.
- iv_tx_data  in  DATA_WIDTH  parallel word to send.
- i_tx_valid  in  1  iv_tx_data is valid.
- o_tx_ready  out  1  block can accept a TX word.
- o_ser_dout  out  1  serial bit to the FIR link, MSB first.
- o_ser_dout_valid  out  1  o_ser_dout is valid.
- i_ser_ready  in  1  FIR link accepts a bit.
- i_ser_din  in  1  serial bit from the FIR link, MSB first.
- i_ser_din_valid  in  1  i_ser_din is valid.
- o_ser_ready  out  1  block accepts a serial bit.
- ov_rx_data  out  DATA_WIDTH  reassembled word.
- o_rx_valid  out  1  ov_rx_data is valid.
- i_rx_ready  in  1  consumer accepts ov_rx_data.

Behaviour:
- Transfer rule: a transfer happens on a rising edge where valid, ready and i_en are all 1. Serial words are DATA_WIDTH bits, MSB first.
- Reset values (i_rst=1, asynchronous): both FSMs go to their first state, shift registers and counters are 0, ov_rx_data=0, o_ser_dout=0, o_rx_valid=0.
- Handshake outputs after reset: o_tx_ready=1 and o_ser_ready=1, both gated by i_en.
- TX FSM, IDLE:
  - o_tx_ready=1, o_ser_dout_valid=0.
  - On a TX transfer: load iv_tx_data into the shift register, set the bit counter to DATA_WIDTH-1, go to SHIFT.
- TX FSM, SHIFT:
  - o_ser_dout_valid=1, o_ser_dout = shift register MSB, o_tx_ready=0.
  - On each serial transfer: shift left by 1 and decrement the counter.
  - A transfer with counter==0 returns to IDLE.
  - A stalled i_ser_ready holds the bit and counter unchanged.
- TX latency and throughput:
  - First bit is presented the cycle after the TX handshake.
  - Minimum TX period is DATA_WIDTH+1 cycles per word; no overlap of load and last bit.
- RX FSM, COLLECT:
  - o_ser_ready=1, o_rx_valid=0.
  - On each serial transfer: shift register <= {shift[DATA_WIDTH-2:0], i_ser_din}, counter increments.
  - On the transfer with counter==DATA_WIDTH-1: register the completed word (including the current bit) into ov_rx_data, clear the counter, go to HOLD.
- RX FSM, HOLD:
  - o_rx_valid=1, o_ser_ready=0.
  - ov_rx_data is stable while held.
  - On an RX transfer (i_rx_ready=1), go to COLLECT; o_rx_valid drops the next cycle.
- RX latency: o_rx_valid rises the cycle after the last bit's handshake.
- i_en low mid-word: counters, shift registers and both FSMs hold. Data resumes exactly where it stopped once i_en returns high.
- i_rst mid-word: the partial word is discarded immediately; no partial output is ever produced.
- i_ser_din_valid during HOLD: not accepted, because o_ser_ready=0.
- TX/RX concurrency: a TX load and an RX completion in the same cycle are independent and both take effect.

Optional Feature:
- Macro: FIR_HOST_WORD_COUNT_EN.
- Defined:
  - Adds outputs ov_tx_words and ov_rx_words, each COUNT_WIDTH bits.
  - ov_tx_words increments on each TX handshake; ov_rx_words increments on each RX handshake.
  - Both reset to 0 and wrap from 2^COUNT_WIDTH-1 to 0.
  - Both hold while i_en=0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then TX 24'hA5C3F0 with i_ser_ready=1 -> o_ser_dout_valid high for 24 cycles, bits 1,0,1,0,0,1,0,1,... MSB first; o_tx_ready returns to 1 on cycle 25.
- Same TX word with i_ser_ready toggling 1,0 each cycle -> identical 24-bit sequence over 48 cycles; bit held during each stall.
- Drive serial 24'h123456 MSB first with i_ser_din_valid=1 and i_rx_ready=0 -> o_rx_valid=1, ov_rx_data=24'h123456, o_ser_ready=0 until i_rx_ready=1, then o_rx_valid=0 next cycle.
- Loop o_ser_dout/o_ser_dout_valid into i_ser_din/i_ser_din_valid, and o_ser_ready into i_ser_ready; send 24'h000001, 24'hFFFFFF, 24'h800000 -> same three words out in order.
- Pull i_en low for 5 cycles after bit 10 of a TX word and after bit 10 of an RX word -> no handshakes during the gap; both words complete correctly afterwards.
- Assert i_rst after 12 RX bits, then send 24'hDEADBE -> ov_rx_data=24'hDEADBE, no stale bits. With FIR_HOST_WORD_COUNT_EN and COUNT_WIDTH=2, 5 TX words -> ov_tx_words=1.

Source files
------------

// File: rtl/fir_stream_host.sv
// Host end of the FIR serial valid/ready link: serializes TX words MSB first and reassembles RX bits into words.
// Define FIR_HOST_WORD_COUNT_EN to add the ov_tx_words / ov_rx_words handshake counters.
module fir_stream_host #(
    parameter int DATA_WIDTH  = 24,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] iv_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic                  o_ser_dout,
    output logic                  o_ser_dout_valid,
    input  logic                  i_ser_ready,
    input  logic                  i_ser_din,
    input  logic                  i_ser_din_valid,
    output logic                  o_ser_ready,
    output logic [DATA_WIDTH-1:0] ov_rx_data,
    output logic                  o_rx_valid,
    input  logic                  i_rx_ready
`ifdef FIR_HOST_WORD_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] ov_tx_words,
    output logic [COUNT_WIDTH-1:0] ov_rx_words
`endif
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DATA_WIDTH < 2 || COUNT_WIDTH < 1) begin : g_bad_param
        $error("fir_stream_host: DATA_WIDTH must be >= 2 and COUNT_WIDTH >= 1");
    end

    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
    typedef enum logic {RX_COLLECT, RX_HOLD} rx_state_t;

    tx_state_t             r_tx_state, w_tx_next;
    rx_state_t             r_rx_state, w_rx_next;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [CNT_W-1:0]      r_tx_cnt;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [CNT_W-1:0]      r_rx_cnt;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  w_tx_load;
    logic                  w_tx_shift;
    logic                  w_rx_bit;
    logic                  w_rx_take;
    logic [DATA_WIDTH-1:0] w_rx_word;

    // Every handshake output is qualified by i_en, so a low enable blocks all transfers.
    assign w_tx_load  = o_tx_ready && i_tx_valid;
    assign w_tx_shift = o_ser_dout_valid && i_ser_ready;
    assign w_rx_bit   = o_ser_ready && i_ser_din_valid;
    assign w_rx_take  = o_rx_valid && i_rx_ready;
    assign w_rx_word  = {r_rx_shift[DATA_WIDTH-2:0], i_ser_din};

    assign o_ser_dout = r_tx_shift[DATA_WIDTH-1];
    assign ov_rx_data = r_rx_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx_state <= TX_IDLE;
            r_rx_state <= RX_COLLECT;
        end else begin
            r_tx_state <= w_tx_next;
            r_rx_state <= w_rx_next;
        end
    end

    always_comb begin
        w_tx_next        = r_tx_state;
        o_tx_ready       = 1'b0;
        o_ser_dout_valid = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                o_tx_ready = i_en;
                if (i_en && i_tx_valid) w_tx_next = TX_SHIFT;
            end
            TX_SHIFT: begin
                o_ser_dout_valid = i_en;
                if (i_en && i_ser_ready && r_tx_cnt == '0) w_tx_next = TX_IDLE;
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        w_rx_next   = r_rx_state;
        o_ser_ready = 1'b0;
        o_rx_valid  = 1'b0;
        case (r_rx_state)
            RX_COLLECT: begin
                o_ser_ready = i_en;
                if (i_en && i_ser_din_valid && r_rx_cnt == CNT_LAST) w_rx_next = RX_HOLD;
            end
            RX_HOLD: begin
                o_rx_valid = i_en;
                if (i_en && i_rx_ready) w_rx_next = RX_COLLECT;
            end
            default: w_rx_next = RX_COLLECT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx_shift <= '0;
            r_tx_cnt   <= '0;
        end else if (w_tx_load) begin
            r_tx_shift <= iv_tx_data;
            r_tx_cnt   <= CNT_LAST;
        end else if (w_tx_shift) begin
            r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            if (r_tx_cnt != '0) r_tx_cnt <= r_tx_cnt - CNT_ONE;
        end
    end

    // The completed word includes the bit arriving on the final handshake.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_shift <= '0;
            r_rx_cnt   <= '0;
            r_rx_data  <= '0;
        end else if (w_rx_bit) begin
            r_rx_shift <= w_rx_word;
            if (r_rx_cnt == CNT_LAST) begin
                r_rx_data <= w_rx_word;
                r_rx_cnt  <= '0;
            end else begin
                r_rx_cnt  <= r_rx_cnt + CNT_ONE;
            end
        end
    end

`ifdef FIR_HOST_WORD_COUNT_EN
    localparam logic [COUNT_WIDTH-1:0] WORD_ONE = COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0] r_tx_words;
    logic [COUNT_WIDTH-1:0] r_rx_words;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx_words <= '0;
            r_rx_words <= '0;
        end else begin
            if (w_tx_load) r_tx_words <= r_tx_words + WORD_ONE;
            if (w_rx_take) r_rx_words <= r_rx_words + WORD_ONE;
        end
    end

    assign ov_tx_words = r_tx_words;
    assign ov_rx_words = r_rx_words;
`endif

endmodule

// File: tb/tb_fir_stream_host.sv
// Self-checking bench for fir_stream_host: directed and randomized TX/RX/loopback traffic against a word-level model.
// Exercises the FIR_HOST_WORD_COUNT_EN counters when that macro is defined.
module tb_fir_stream_host;

    localparam int W  = 24;
    localparam int CW = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         drv_ser_ready;
    logic         drv_ser_din;
    logic         drv_ser_din_valid;
    logic         rx_ready;
    logic         loop_mode;

    logic         o_tx_ready;
    logic         o_ser_dout;
    logic         o_ser_dout_valid;
    logic         o_ser_ready;
    logic [W-1:0] ov_rx_data;
    logic         o_rx_valid;
    logic         w_ser_ready;
    logic         w_ser_din;
    logic         w_ser_din_valid;
`ifdef FIR_HOST_WORD_COUNT_EN
    logic [CW-1:0] ov_tx_words;
    logic [CW-1:0] ov_rx_words;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    assign w_ser_ready     = loop_mode ? o_ser_ready      : drv_ser_ready;
    assign w_ser_din       = loop_mode ? o_ser_dout       : drv_ser_din;
    assign w_ser_din_valid = loop_mode ? o_ser_dout_valid : drv_ser_din_valid;

    always #5 clk = ~clk;

    fir_stream_host #(.DATA_WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_en             (en),
        .iv_tx_data       (tx_data),
        .i_tx_valid       (tx_valid),
        .o_tx_ready       (o_tx_ready),
        .o_ser_dout       (o_ser_dout),
        .o_ser_dout_valid (o_ser_dout_valid),
        .i_ser_ready      (w_ser_ready),
        .i_ser_din        (w_ser_din),
        .i_ser_din_valid  (w_ser_din_valid),
        .o_ser_ready      (o_ser_ready),
        .ov_rx_data       (ov_rx_data),
        .o_rx_valid       (o_rx_valid),
        .i_rx_ready       (rx_ready)
`ifdef FIR_HOST_WORD_COUNT_EN
        ,
        .ov_tx_words      (ov_tx_words),
        .ov_rx_words      (ov_rx_words)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // mode 0: ready always 1, 1: ready toggles 1,0,..., 2: random ready
    task automatic tx_word(input logic [W-1:0] word, input int mode, input int gap_at, input string tag);
        logic [W-1:0] got = '0;
        int nbits = 0, cycles = 0, bad = 0, gap_bad = 0;
        bit gap_done = 0, ready, prev_stall = 0, prev_bit = 0;
        @(negedge clk);
        tx_data  = word;
        tx_valid = 1'b1;
        #1;
        check_eq({tag, "_ready_before"}, o_tx_ready, 1'b1);
        @(posedge clk);
        while (nbits < W && cycles < 200) begin
            @(negedge clk);
            tx_valid = 1'b0;
            if (nbits == gap_at && !gap_done) begin
                gap_done = 1;
                en = 1'b0;
                drv_ser_ready = 1'b1;
                repeat (5) begin
                    #1;
                    if (o_ser_dout_valid || o_tx_ready || o_ser_ready || o_rx_valid) gap_bad++;
                    @(negedge clk);
                end
                en = 1'b1;
            end
            case (mode)
                0:       ready = 1'b1;
                1:       ready = (cycles % 2 == 0);
                default: ready = 1'($urandom % 2);
            endcase
            drv_ser_ready = ready;
            #1;
            cycles++;
            if (o_ser_dout_valid !== 1'b1 || o_tx_ready !== 1'b0) bad++;
            if (prev_stall && o_ser_dout !== prev_bit) bad++;
            if (ready) begin
                got = {got[W-2:0], o_ser_dout};
                nbits++;
            end
            prev_stall = !ready;
            prev_bit   = o_ser_dout;
            @(posedge clk);
        end
        @(negedge clk);
        drv_ser_ready = 1'b0;
        #1;
        check_eq({tag, "_word"}, got, word);
        check_eq({tag, "_bits_done"}, nbits, W);
        check_eq({tag, "_hs_errors"}, bad, 0);
        check_eq({tag, "_ready_after"}, o_tx_ready, 1'b1);
        check_eq({tag, "_valid_after"}, o_ser_dout_valid, 1'b0);
        if (gap_at >= 0) check_eq({tag, "_gap_hs"}, gap_bad, 0);
        if (mode == 0 && gap_at < 0) check_eq({tag, "_cycles"}, cycles, W);
        // ready high on even cycles only: last bit goes on cycle 2W-1
        if (mode == 1) check_eq({tag, "_cycles"}, cycles, 2 * W - 1);
    endtask

    task automatic rx_bits(input logic [W-1:0] word, input int n, input int gap_at,
                           input bit rand_gaps, input string tag);
        int nbits = 0, cycles = 0, bad = 0;
        bit gap_done = 0, v;
        while (nbits < n && cycles < 300) begin
            @(negedge clk);
            if (nbits == gap_at && !gap_done) begin
                gap_done = 1;
                en = 1'b0;
                drv_ser_din_valid = 1'b1;
                drv_ser_din = ~word[W-1-nbits];
                repeat (5) begin
                    #1;
                    if (o_ser_ready || o_rx_valid || o_tx_ready) bad++;
                    @(negedge clk);
                end
                en = 1'b1;
            end
            v = rand_gaps ? ($urandom % 4 != 0) : 1'b1;
            drv_ser_din_valid = v;
            drv_ser_din = word[W-1-nbits];
            #1;
            cycles++;
            if (o_rx_valid !== 1'b0) bad++;
            if (v && o_ser_ready) nbits++;
            @(posedge clk);
        end
        check_eq({tag, "_bits_sent"}, nbits, n);
        check_eq({tag, "_collect_errors"}, bad, 0);
    endtask

    task automatic rx_expect(input logic [W-1:0] word, input int hold, input string tag);
        int bad = 0;
        @(negedge clk);
        drv_ser_din_valid = 1'b1;
        drv_ser_din = 1'b1;
        #1;
        check_eq({tag, "_valid"}, o_rx_valid, 1'b1);
        check_eq({tag, "_data"}, ov_rx_data, word);
        check_eq({tag, "_ser_ready_hold"}, o_ser_ready, 1'b0);
        repeat (hold) begin
            @(negedge clk);
            drv_ser_din = 1'($urandom % 2);
            #1;
            if (o_rx_valid !== 1'b1 || ov_rx_data !== word || o_ser_ready !== 1'b0) bad++;
        end
        check_eq({tag, "_hold_stable"}, bad, 0);
        rx_ready = 1'b1;
        drv_ser_din_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rx_ready = 1'b0;
        #1;
        check_eq({tag, "_valid_drop"}, o_rx_valid, 1'b0);
        check_eq({tag, "_ser_ready_back"}, o_ser_ready, 1'b1);
    endtask

    task automatic loopback(input logic [W-1:0] words[$]);
        logic [W-1:0] q_tx[$];
        logic [W-1:0] q_exp[$];
        int cycles = 0;
        bit tx_go, rx_go;
        q_tx  = words;
        q_exp = words;
        loop_mode = 1'b1;
        while (q_exp.size() > 0 && cycles < 5000) begin
            @(negedge clk);
            cycles++;
            #1;
            tx_go = (q_tx.size() > 0) && o_tx_ready;
            tx_valid = tx_go;
            if (tx_go) tx_data = q_tx[0];
            rx_go = o_rx_valid && ($urandom % 2 == 0);
            rx_ready = rx_go;
            if (rx_go) begin
                check_eq("loop_word", ov_rx_data, q_exp[0]);
                void'(q_exp.pop_front());
            end
            @(posedge clk);
            if (tx_go) void'(q_tx.pop_front());
        end
        check_eq("loop_all_received", q_exp.size(), 0);
        @(negedge clk);
        tx_valid  = 1'b0;
        rx_ready  = 1'b0;
        loop_mode = 1'b0;
    endtask

    initial begin
        logic [W-1:0] lw[$];
        logic [W-1:0] rw;
        rst = 1'b1;
        en = 1'b1;
        tx_data = '0;
        tx_valid = 1'b0;
        drv_ser_ready = 1'b0;
        drv_ser_din = 1'b0;
        drv_ser_din_valid = 1'b0;
        rx_ready = 1'b0;
        loop_mode = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_tx_ready", o_tx_ready, 1'b1);
        check_eq("rst_ser_ready", o_ser_ready, 1'b1);
        check_eq("rst_dout_valid", o_ser_dout_valid, 1'b0);
        check_eq("rst_rx_valid", o_rx_valid, 1'b0);
        check_eq("rst_rx_data", ov_rx_data, '0);
        check_eq("rst_ser_dout", o_ser_dout, 1'b0);

        tx_word(24'hA5C3F0, 0, -1, "tx_a5");
        tx_word(24'hA5C3F0, 1, -1, "tx_toggle");
        for (int i = 0; i < 4; i++) tx_word(W'($urandom), 2, -1, "tx_rand");

        rx_bits(24'h123456, W, -1, 1'b0, "rx_123");
        rx_expect(24'h123456, 4, "rx_123");
        for (int i = 0; i < 4; i++) begin
            rw = W'($urandom);
            rx_bits(rw, W, -1, 1'b1, "rx_rand");
            rx_expect(rw, int'($urandom_range(0, 3)), "rx_rand");
        end

        lw = '{24'h000001, 24'hFFFFFF, 24'h800000};
        for (int i = 0; i < 6; i++) lw.push_back(W'($urandom));
        loopback(lw);

        tx_word(24'h5A3C96, 0, 10, "tx_en_gap");
        rx_bits(24'hC0FFEE, W, 10, 1'b0, "rx_en_gap");
        rx_expect(24'hC0FFEE, 1, "rx_en_gap");

        rx_bits(24'hFFFFFF, 12, -1, 1'b0, "rx_partial");
        @(negedge clk);
        drv_ser_din_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("midrst_ser_ready", o_ser_ready, 1'b1);
        check_eq("midrst_rx_data", ov_rx_data, '0);
        @(negedge clk);
        rst = 1'b0;
        rx_bits(24'hDEADBE, W, -1, 1'b0, "rx_dead");
        rx_expect(24'hDEADBE, 2, "rx_dead");

`ifdef FIR_HOST_WORD_COUNT_EN
        do_reset();
        #1;
        check_eq("cnt_tx_rst", ov_tx_words, '0);
        for (int i = 0; i < 5; i++) tx_word(W'($urandom), 0, -1, "cnt_tx");
        check_eq("cnt_tx_wrap", ov_tx_words, 2'd1);
        for (int i = 0; i < 3; i++) begin
            rw = W'($urandom);
            rx_bits(rw, W, -1, 1'b0, "cnt_rx");
            rx_expect(rw, 0, "cnt_rx");
        end
        check_eq("cnt_rx", ov_rx_words, 2'd3);
`else
        do_reset();
        #1;
        check_eq("final_rst_tx_ready", o_tx_ready, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
